// File: rtl/sm4_encryptor_pkg.sv
// Shared constants, types and helpers for the SM4 round scheduler.
package sm4_encryptor_pkg;

  localparam int unsigned RoundW = 5;

  // System parameter FK0..FK3, FK0 in the top word.
  localparam logic [127:0] FkWord = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

  typedef enum logic [1:0] {StIdle, StKeyExp, StCrypt, StDone} sm4_state_e;

  // CK[i] lives at [i*32 +: 32]; byte j of CK[i] (j=0 is the top byte) is (4i+j)*7 mod 256.
  function automatic logic [1023:0] gen_ck();
    logic [1023:0] t;
    logic [9:0]    v;
    t = '0;
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) begin
        v = 10'((4 * i + j) * 7);
        t[i*32 + (3-j)*8 +: 8] = v[7:0];
      end
    end
    return t;
  endfunction

  localparam logic [1023:0] CkTable = gen_ck();

  // S-box, entry 0 in the top byte.
  localparam logic [2047:0] SboxTable = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  function automatic logic [31:0] rol(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    logic [31:0] b;
    for (int k = 0; k < 4; k++) begin
      b[k*8 +: 8] = SboxTable[{~a[k*8 +: 8], 3'b000} +: 8];
    end
    return b;
  endfunction

  // Swaps the word order so the first (top) word lands in [31:0].
  function automatic logic [127:0] word_rev(input logic [127:0] x);
    return {x[31:0], x[63:32], x[95:64], x[127:96]};
  endfunction

endpackage

// File: rtl/sm4_round_scheduler_mask_lfsr.sv
// Mask source: 32-bit Galois LFSR plus the previous-round mask register.
module sm4_mask_lfsr #(
  parameter bit          mask_en_p   = 1'b1,
  parameter logic [31:0] lfsr_seed_p = 32'h1357_9BDF
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        advance_i,
  input  logic        first_i,
  input  logic [31:0] round_mask_i,
  output logic [31:0] mask_o,
  output logic [31:0] dismask_o
);

  localparam logic [31:0] Taps = 32'h8020_0003;

  logic [31:0] lfsr_q, dismask_q;

  // Step the LFSR and capture this round's mask once per active round.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lfsr_q    <= lfsr_seed_p;
      dismask_q <= '0;
    end else if (advance_i) begin
      lfsr_q    <= {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? Taps : 32'h0);
      dismask_q <= round_mask_i;
    end
  end

  // Round 0 of a pass has no previous mask to strip.
  always_comb begin
    mask_o    = mask_en_p ? lfsr_q : 32'h0;
    dismask_o = (mask_en_p && !first_i) ? dismask_q : 32'h0;
  end

endmodule

// File: rtl/turn_transform.sv
// One SM4 round: o = X0 ^ L(tau(X1 ^ X2 ^ X3 ^ rk)), with L' for key expansion.
// Mask shares are applied to the operands and stripped before the table S-box, so the
// result is independent of the mask values.
module turn_transform
  import sm4_encryptor_pkg::*;
(
  input  logic [127:0] i,
  input  logic [31:0]  rkey_i,
  input  logic         key_mode_i,
  input  logic [31:0]  mask_i,
  input  logic [31:0]  dismask_i,
  output logic [31:0]  o,
  output logic [31:0]  mask_o
);

  logic [31:0] x0_m, a_m, b, c;

  // Round function on masked shares.
  always_comb begin
    x0_m = i[31:0] ^ dismask_i;
    a_m  = i[63:32] ^ i[95:64] ^ i[127:96] ^ rkey_i ^ mask_i;
    b    = tau(a_m ^ mask_i);
    if (key_mode_i) begin
      c = b ^ rol(b, 13) ^ rol(b, 23);
    end else begin
      c = b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
    end
    o      = x0_m ^ dismask_i ^ c;
    mask_o = mask_i;
  end

endmodule

// File: rtl/sm4_round_scheduler.sv
// Iterative SM4 controller: key expansion into a 32-entry round-key file, then
// 32-round encrypt/decrypt passes, one round per cycle, with valid/ready handshakes.
module sm4_round_scheduler
  import sm4_encryptor_pkg::*;
#(
  parameter bit          mask_en_p   = 1'b1,
  parameter logic [31:0] lfsr_seed_p = 32'h1357_9BDF
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         key_v_i,
  input  logic [127:0] key_i,
  output logic         key_ready_o,
  input  logic         data_v_i,
  input  logic [127:0] data_i,
  input  logic         decrypt_i,
  output logic         data_ready_o,
  output logic         data_v_o,
  output logic [127:0] data_o,
  input  logic         data_ready_i,
  output logic         keys_valid_o,
  output logic         busy_o
);

  sm4_state_e          state_q, state_d;
  logic [RoundW-1:0]   round_q, round_d;
  logic [127:0]        s_q, s_d;
  logic                keys_valid_q, keys_valid_d;
  logic                decrypt_q, decrypt_d;
  logic [31:0]         rk_q [32];

  logic                key_hs, data_hs, round_active, last_round;
  logic [31:0]         rkey, rnd_out, rnd_mask, mask_w, dismask_w;

  assign key_ready_o  = (state_q == StIdle);
  assign data_ready_o = (state_q == StIdle) & keys_valid_q & ~key_v_i;
  assign data_v_o     = (state_q == StDone);
  assign data_o       = s_q;
  assign keys_valid_o = keys_valid_q;
  assign busy_o       = (state_q != StIdle);

  assign key_hs       = key_v_i & key_ready_o;
  assign data_hs      = data_v_i & data_ready_o;
  assign round_active = (state_q == StKeyExp) | (state_q == StCrypt);
  assign last_round   = (round_q == RoundW'(31));

  // Round key: CK during expansion, RK forward or reversed during a pass.
  always_comb begin
    rkey = rk_q[round_q];
    if (state_q == StKeyExp) begin
      rkey = CkTable[round_q*32 +: 32];
    end else if (decrypt_q) begin
      rkey = rk_q[~round_q];
    end
  end

  turn_transform u_round (
    .i          (s_q),
    .rkey_i     (rkey),
    .key_mode_i (state_q == StKeyExp),
    .mask_i     (mask_w),
    .dismask_i  (dismask_w),
    .o          (rnd_out),
    .mask_o     (rnd_mask)
  );

  sm4_mask_lfsr #(
    .mask_en_p   (mask_en_p),
    .lfsr_seed_p (lfsr_seed_p)
  ) u_mask (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .advance_i    (round_active),
    .first_i      (round_q == '0),
    .round_mask_i (rnd_mask),
    .mask_o       (mask_w),
    .dismask_o    (dismask_w)
  );

  // Next-state: handshakes in IDLE, one round per cycle, hold result until consumed.
  always_comb begin
    state_d      = state_q;
    round_d      = round_q;
    s_d          = s_q;
    keys_valid_d = keys_valid_q;
    decrypt_d    = decrypt_q;
    unique case (state_q)
      StIdle: begin
        if (key_hs) begin
          s_d          = word_rev(key_i ^ FkWord);
          keys_valid_d = 1'b0;
          round_d      = '0;
          state_d      = StKeyExp;
        end else if (data_hs) begin
          s_d       = word_rev(data_i);
          decrypt_d = decrypt_i;
          round_d   = '0;
          state_d   = StCrypt;
        end
      end
      StKeyExp: begin
        s_d     = {rnd_out, s_q[127:32]};
        round_d = round_q + RoundW'(1);
        if (last_round) begin
          keys_valid_d = 1'b1;
          state_d      = StIdle;
        end
      end
      StCrypt: begin
        s_d     = {rnd_out, s_q[127:32]};
        round_d = round_q + RoundW'(1);
        if (last_round) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (data_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and state registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      round_q      <= '0;
      s_q          <= '0;
      keys_valid_q <= 1'b0;
      decrypt_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      s_q          <= s_d;
      keys_valid_q <= keys_valid_d;
      decrypt_q    <= decrypt_d;
    end
  end

  // Round-key file; contents are meaningless until keys_valid_o.
  always_ff @(posedge clk_i) begin
    if (state_q == StKeyExp) begin
      rk_q[round_q] <= rnd_out;
    end
  end

endmodule

// File: tb/tb_sm4_round_scheduler.sv
// Directed bench: two instances with different LFSR seeds share all inputs.
module tb_sm4_round_scheduler;

  localparam logic [127:0] Key = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] Ct  = 128'h681EDF34D206965E86B3E94F536E4246;
  localparam logic [31:0]  Rk0 = 32'hF12186F9;
  localparam logic [31:0]  Rk31 = 32'h9124A012;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         key_v = 1'b0, data_v = 1'b0, decrypt = 1'b0, data_ready = 1'b1;
  logic [127:0] key = '0, data = '0;

  logic         key_ready0, data_ready0, data_v0, keys_valid0, busy0;
  logic         key_ready1, data_ready1, data_v1, keys_valid1, busy1;
  logic [127:0] data_o0, data_o1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sm4_round_scheduler dut0 (
    .clk_i(clk), .reset_i(reset), .key_v_i(key_v), .key_i(key), .key_ready_o(key_ready0),
    .data_v_i(data_v), .data_i(data), .decrypt_i(decrypt), .data_ready_o(data_ready0),
    .data_v_o(data_v0), .data_o(data_o0), .data_ready_i(data_ready),
    .keys_valid_o(keys_valid0), .busy_o(busy0)
  );

  sm4_round_scheduler #(.lfsr_seed_p(32'hDEAD_BEEF)) dut1 (
    .clk_i(clk), .reset_i(reset), .key_v_i(key_v), .key_i(key), .key_ready_o(key_ready1),
    .data_v_i(data_v), .data_i(data), .decrypt_i(decrypt), .data_ready_o(data_ready1),
    .data_v_o(data_v1), .data_o(data_o1), .data_ready_i(data_ready),
    .keys_valid_o(keys_valid1), .busy_o(busy1)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Key handshake, then count edges until keys_valid_o.
  task automatic do_key(input logic [127:0] k, output int lat);
    @(negedge clk);
    key_v = 1'b1;
    key = k;
    chk("key_ready", 128'(key_ready0), 128'(1));
    @(posedge clk);
    #1 key_v = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (keys_valid0) break;
    end
  endtask

  // Data handshake, then count edges until data_v_o; returns both results.
  task automatic do_crypt(input logic [127:0] din, input logic dec,
                          output logic [127:0] r0, output logic [127:0] r1,
                          output int lat);
    @(negedge clk);
    data_v = 1'b1;
    data = din;
    decrypt = dec;
    chk("data_ready", {data_ready1, data_ready0}, 128'(2'b11));
    @(posedge clk);
    #1 data_v = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (data_v0) break;
    end
    chk("data_v_o both", {data_v1, data_v0}, 128'(2'b11));
    r0 = data_o0;
    r1 = data_o1;
  endtask

  typedef struct {
    logic         is_key;
    logic [127:0] din;
    logic         dec;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[4];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int lat;
    logic [127:0] r0, r1, snap;
    logic seen_ready;

    vecs[0] = '{is_key: 1'b1, din: Key, dec: 1'b0, exp: {64'h0, Rk0, Rk31}};
    vecs[1] = '{is_key: 1'b0, din: Key, dec: 1'b0, exp: Ct};
    vecs[2] = '{is_key: 1'b0, din: Ct,  dec: 1'b1, exp: Key};
    vecs[3] = '{is_key: 1'b0, din: Key, dec: 1'b0, exp: Ct};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset state", {key_ready0, data_ready0, data_v0, keys_valid0, busy0},
        128'(5'b10000));

    // No key yet: data must never be accepted.
    data_v = 1'b1;
    data = Key;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("no key data held", {data_ready0, busy0}, 128'(0));
    end

    // Key and data together: key wins, data held off through expansion.
    key_v = 1'b1;
    key = Key;
    chk("key+data ready", {key_ready0, data_ready0}, 128'(2'b10));
    @(posedge clk);
    #1 key_v = 1'b0;
    seen_ready = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (keys_valid0) break;
      if (data_ready0 || !busy0) seen_ready = 1'b1;
    end
    data_v = 1'b0;
    chk("data held during keyexp", 128'(seen_ready), 128'(0));
    chk("first key latency", 128'(lat), 128'(32));

    foreach (vecs[n]) begin
      if (vecs[n].is_key) begin
        do_key(vecs[n].din, lat);
        chk("key latency", 128'(lat), 128'(32));
        chk("keys_valid both", {keys_valid1, keys_valid0}, 128'(2'b11));
        chk("RK pair dut0", {64'h0, dut0.rk_q[0], dut0.rk_q[31]}, vecs[n].exp);
        chk("RK pair dut1", {64'h0, dut1.rk_q[0], dut1.rk_q[31]}, vecs[n].exp);
      end else begin
        do_crypt(vecs[n].din, vecs[n].dec, r0, r1, lat);
        chk("crypt latency", 128'(lat), 128'(32));
        chk(vecs[n].dec ? "decrypt dut0" : "encrypt dut0", r0, vecs[n].exp);
        chk(vecs[n].dec ? "decrypt dut1" : "encrypt dut1", r1, vecs[n].exp);
      end
    end

    // Back-pressure in DONE: result stable, no input accepted.
    @(negedge clk);
    data_ready = 1'b0;
    do_crypt(Key, 1'b0, r0, r1, lat);
    chk("stall encrypt", r0, Ct);
    snap = r0;
    data_v = 1'b1;
    data = Ct;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall hold", {data_o0 ^ snap, 1'b0, key_ready0, data_ready0, data_v0},
          128'(4'b0001));
    end
    data_v = 1'b0;
    data_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release to idle", {busy0, data_v0, key_ready0}, 128'(3'b001));

    // Reset in round 15 of a pass abandons it and clears the key file validity.
    @(negedge clk);
    data_v = 1'b1;
    data = Key;
    decrypt = 1'b0;
    @(posedge clk);
    #1 data_v = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("busy before reset", 128'(busy0), 128'(1));
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid reset dut0", {busy0, keys_valid0, data_v0, data_ready0}, 128'(0));
    chk("mid reset dut1", {busy1, keys_valid1, data_v1, data_ready1}, 128'(0));

    do_key(Key, lat);
    chk("rekey latency", 128'(lat), 128'(32));
    do_crypt(Key, 1'b0, r0, r1, lat);
    chk("post reset latency", 128'(lat), 128'(32));
    chk("post reset dut0", r0, Ct);
    chk("post reset dut1", r1, Ct);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
